lc_port_arbiter: RTL and testbench

LC_PORT_ARBITER -- requirements
Module: lc_port_arbiter

---
 rtl/lc_port_arbiter_if.sv | 56 +++++
 rtl/lc_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_lc_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc_port_arbiter_if.sv
// Bundles the client request/response lanes, the downstream request/response
// channels and the status outputs of lc_port_arbiter.
interface lc_port_arbiter_if #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_BITS   = 64,
  parameter int LINE_BITS   = 512,
  parameter int OWNER_DEPTH = 4
);
  localparam int CNT_W = $clog2(OWNER_DEPTH) + 1;

  // client request lanes
  logic [NUM_PORTS-1:0]           port_valid_in;
  logic [NUM_PORTS-1:0]           port_ready_out;
  logic [NUM_PORTS*ADDR_BITS-1:0] port_addr_in;
  logic [NUM_PORTS*LINE_BITS-1:0] port_value_in;
  logic [NUM_PORTS-1:0]           port_we_in;

  // client response lanes (address/data shared by all clients)
  logic [NUM_PORTS-1:0]           port_valid_out;
  logic [NUM_PORTS-1:0]           port_ready_in;
  logic [ADDR_BITS-1:0]           port_addr_out;
  logic [LINE_BITS-1:0]           port_value_out;

  // downstream request channel
  logic                           lc_valid_out;
  logic                           lc_ready_in;
  logic [ADDR_BITS-1:0]           lc_addr_out;
  logic [LINE_BITS-1:0]           lc_value_out;
  logic                           lc_we_out;

  // downstream response channel
  logic                           lc_valid_in;
  logic                           lc_ready_out;
  logic [ADDR_BITS-1:0]           lc_addr_in;
  logic [LINE_BITS-1:0]           lc_value_in;

  // status
  logic [CNT_W-1:0]               outstanding_out;
  logic                           err_out;

  modport slave (
    input  port_valid_in, port_addr_in, port_value_in, port_we_in, port_ready_in,
    input  lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
    output port_ready_out, port_valid_out, port_addr_out, port_value_out,
    output lc_valid_out, lc_addr_out, lc_value_out, lc_we_out, lc_ready_out,
    output outstanding_out, err_out
  );

  modport master (
    output port_valid_in, port_addr_in, port_value_in, port_we_in, port_ready_in,
    output lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
    input  port_ready_out, port_valid_out, port_addr_out, port_value_out,
    input  lc_valid_out, lc_addr_out, lc_value_out, lc_we_out, lc_ready_out,
    input  outstanding_out, err_out
  );
endinterface

// File: rtl/lc_port_arbiter.sv
// Round-robin arbiter merging L1 client requests onto one downstream channel;
// read owners are queued so in-order read responses route back to their client.
module lc_port_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_BITS   = 64,
  parameter int LINE_BITS   = 512,
  parameter int OWNER_DEPTH = 4
) (
  input logic              clk_in,
  input logic              rst_in,
  lc_port_arbiter_if.slave bus
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W  = $clog2(OWNER_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [PORT_W-1:0] LAST_PORT  = PORT_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0]  FIFO_DEPTH = CNT_W'(OWNER_DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state;
  logic [PORT_W-1:0]     last_grant;
  logic [PORT_W-1:0]     grant_idx;
  logic                  grant_valid;
  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  ready;

  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_BITS-1:0]  req_addr;
  logic [LINE_BITS-1:0]  req_value;

  logic [PORT_W-1:0]     owner_mem [OWNER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  logic                  resp_full;
  logic [PORT_W-1:0]     resp_owner;
  logic [ADDR_BITS-1:0]  resp_addr;
  logic [LINE_BITS-1:0]  resp_value;
  logic [NUM_PORTS-1:0]  resp_valid;
  logic                  lc_ready;
  logic                  err;

  assign fifo_full  = (count == FIFO_DEPTH);
  assign fifo_empty = (count == '0);
  assign lc_ready   = !fifo_empty && !resp_full;
  assign push       = (state == ISSUE) && req_valid && bus.lc_ready_in && !req_we;
  assign pop        = bus.lc_valid_in && lc_ready;

  // Reads need an owner slot; writes never return, so they bypass a full FIFO.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = bus.port_valid_in[i] && (bus.port_we_in[i] || !fifo_full);
    end
  end

  always_comb begin
    int unsigned       idx;
    logic [PORT_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx  = (32'(last_grant) + k) % NUM_PORTS;
      cand = PORT_W'(idx);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gated by rst_in so the combinational accept is also forced low during reset.
  always_comb begin
    ready = '0;
    if ((state == IDLE) && grant_valid && !rst_in) begin
      ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      last_grant <= LAST_PORT;
      req_valid  <= 1'b0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_value  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_idx;
            req_addr   <= bus.port_addr_in[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
            req_value  <= bus.port_value_in[int'(grant_idx)*LINE_BITS +: LINE_BITS];
            req_we     <= bus.port_we_in[grant_idx];
            req_valid  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.lc_ready_in) begin
            req_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // last_grant still names the owner of the request being issued.
  always_ff @(posedge clk_in) begin
    if (push) begin
      owner_mem[wr_ptr] <= last_grant;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      resp_full  <= 1'b0;
      resp_owner <= '0;
      resp_addr  <= '0;
      resp_value <= '0;
      err        <= 1'b0;
    end else begin
      if (pop) begin
        resp_full  <= 1'b1;
        resp_owner <= owner_mem[rd_ptr];
        resp_addr  <= bus.lc_addr_in;
        resp_value <= bus.lc_value_in;
      end else if (resp_full && bus.port_ready_in[resp_owner]) begin
        resp_full <= 1'b0;
      end
      if (bus.lc_valid_in && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (resp_full) begin
      resp_valid[resp_owner] = 1'b1;
    end
  end

  assign bus.port_ready_out  = ready;
  assign bus.port_valid_out  = resp_valid;
  assign bus.port_addr_out   = resp_addr;
  assign bus.port_value_out  = resp_value;
  assign bus.lc_valid_out    = req_valid;
  assign bus.lc_addr_out     = req_addr;
  assign bus.lc_value_out    = req_value;
  assign bus.lc_we_out       = req_we;
  assign bus.lc_ready_out    = lc_ready;
  assign bus.outstanding_out = count;
  assign bus.err_out         = err;
endmodule

// File: tb/tb_lc_port_arbiter.sv
// Scoreboard bench for lc_port_arbiter: directed stimulus pushes expected grants,
// downstream requests and client responses; negedge monitors pop and compare.
module tb_lc_port_arbiter;
  localparam int NP = 2;
  localparam int AB = 32;
  localparam int LB = 64;
  localparam int OD = 4;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [LB-1:0] value;
    logic          we;
  } req_t;

  typedef struct packed {
    logic [NP-1:0] vec;
    logic [AB-1:0] addr;
    logic [LB-1:0] value;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .LINE_BITS(LB), .OWNER_DEPTH(OD)) bus ();

  lc_port_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .LINE_BITS(LB), .OWNER_DEPTH(OD)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int    total = 0;
  int    bad   = 0;
  int    grant_q[$];
  req_t  req_q[$];
  resp_t resp_q[$];
  int    cyc = 0;
  int    accept_cyc = -10;
  logic  prev_lcv = 1'b0;
  int    mon_g;
  req_t  mon_r;
  resp_t mon_s;

  req_t  preq [NP][16];
  int    pn [NP];
  int    pi [NP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] rv(input logic [AB-1:0] a);
    return {a ^ 32'hFFFF_0000, a};
  endfunction

  task automatic enq(input int p, input logic [AB-1:0] a, input logic [LB-1:0] v, input logic we);
    preq[p][pn[p]] = '{addr: a, value: v, we: we};
    pn[p]++;
  endtask

  task automatic exp_req(input logic [AB-1:0] a, input logic [LB-1:0] v, input logic we);
    req_q.push_back('{addr: a, value: v, we: we});
  endtask

  task automatic exp_resp(input logic [NP-1:0] vec, input logic [AB-1:0] a, input logic [LB-1:0] v);
    resp_q.push_back('{vec: vec, addr: a, value: v});
  endtask

  task automatic lc_respond(input logic [AB-1:0] a, input logic [LB-1:0] v);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.lc_valid_in = 1'b1;
    bus.lc_addr_in  = a;
    bus.lc_value_in = v;
    @(negedge clk);
    while (!bus.lc_ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("lc_resp_accept", 64'(bus.lc_ready_out), 1);
    @(posedge clk); #1;
    bus.lc_valid_in = 1'b0;
  endtask

  task automatic wait_outst(input int v, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(bus.outstanding_out) != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(bus.outstanding_out), 64'(v));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((grant_q.size() + req_q.size() + resp_q.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(grant_q.size() + req_q.size() + resp_q.size()), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // grant monitor
  always @(negedge clk) begin
    if (bus.port_ready_out != '0) begin
      if (grant_q.size() == 0) begin
        chk("grant_unexpected", 64'(bus.port_ready_out), 0);
      end else begin
        mon_g = grant_q.pop_front();
        chk("grant_port", 64'(bus.port_ready_out), 64'(1) << mon_g);
      end
      accept_cyc <= cyc;
    end
  end

  // downstream request monitor
  always @(negedge clk) begin
    if (bus.lc_valid_out && !prev_lcv) chk("issue_latency", 64'(cyc), 64'(accept_cyc + 1));
    prev_lcv <= bus.lc_valid_out;
    if (bus.lc_valid_out && bus.lc_ready_in) begin
      if (req_q.size() == 0) begin
        chk("req_unexpected", 64'(bus.lc_addr_out), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_r = req_q.pop_front();
        chk("req_addr",  64'(bus.lc_addr_out), 64'(mon_r.addr));
        chk("req_value", bus.lc_value_out, mon_r.value);
        chk("req_we",    64'(bus.lc_we_out), 64'(mon_r.we));
      end
    end
  end

  // client response monitor
  always @(negedge clk) begin
    if (bus.port_valid_out != '0) begin
      chk("resp_onehot", 64'($onehot(bus.port_valid_out)), 1);
      if ((bus.port_valid_out & bus.port_ready_in) != '0) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 64'(bus.port_valid_out), 0);
        end else begin
          mon_s = resp_q.pop_front();
          chk("resp_vec",   64'(bus.port_valid_out), 64'(mon_s.vec));
          chk("resp_addr",  64'(bus.port_addr_out), 64'(mon_s.addr));
          chk("resp_value", bus.port_value_out, mon_s.value);
        end
      end
    end
  end

  // client request driver: holds each queued request until it is accepted
  initial begin
    logic [NP-1:0] acc;
    bus.port_valid_in = '0;
    bus.port_addr_in  = '0;
    bus.port_value_in = '0;
    bus.port_we_in    = '0;
    for (int p = 0; p < NP; p++) begin
      pn[p] = 0;
      pi[p] = 0;
    end
    forever begin
      @(negedge clk);
      acc = bus.port_valid_in & bus.port_ready_out;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) pi[p]++;
        if (pi[p] < pn[p]) begin
          bus.port_valid_in[p]            = 1'b1;
          bus.port_addr_in[p*AB +: AB]    = preq[p][pi[p]].addr;
          bus.port_value_in[p*LB +: LB]   = preq[p][pi[p]].value;
          bus.port_we_in[p]               = preq[p][pi[p]].we;
        end else begin
          bus.port_valid_in[p] = 1'b0;
          bus.port_we_in[p]    = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.lc_ready_in   = 1'b1;
    bus.lc_valid_in   = 1'b0;
    bus.lc_addr_in    = '0;
    bus.lc_value_in   = '0;
    bus.port_ready_in = 2'b11;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_port_ready",  64'(bus.port_ready_out), 0);
    chk("rst_lc_valid",    64'(bus.lc_valid_out), 0);
    chk("rst_lc_we",       64'(bus.lc_we_out), 0);
    chk("rst_lc_ready",    64'(bus.lc_ready_out), 0);
    chk("rst_lc_addr",     64'(bus.lc_addr_out), 0);
    chk("rst_port_valid",  64'(bus.port_valid_out), 0);
    chk("rst_port_addr",   64'(bus.port_addr_out), 0);
    chk("rst_outstanding", 64'(bus.outstanding_out), 0);
    chk("rst_err",         64'(bus.err_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // alternating reads fill the owner FIFO; read stalls when full, write passes
    @(negedge clk);
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0);
    grant_q.push_back(1); grant_q.push_back(1);
    exp_req(32'h100, 64'h11, 1'b0);
    exp_req(32'h200, 64'h21, 1'b0);
    exp_req(32'h104, 64'h12, 1'b0);
    exp_req(32'h204, 64'h22, 1'b0);
    exp_req(32'h300, 64'hDEAD_BEEF_0000_0001, 1'b1);
    enq(0, 32'h100, 64'h11, 1'b0);
    enq(0, 32'h104, 64'h12, 1'b0);
    enq(0, 32'h108, 64'h13, 1'b0);
    enq(1, 32'h200, 64'h21, 1'b0);
    enq(1, 32'h204, 64'h22, 1'b0);
    enq(1, 32'h300, 64'hDEAD_BEEF_0000_0001, 1'b1);
    wait_drain("fill_drain");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_read_stall", 64'(bus.port_ready_out), 0);
      chk("full_outstanding", 64'(bus.outstanding_out), 4);
    end

    // in-order responses; the stalled port 0 read proceeds once a slot frees
    grant_q.push_back(0);
    exp_req(32'h108, 64'h13, 1'b0);
    exp_resp(2'b01, 32'h100, rv(32'h100));
    exp_resp(2'b10, 32'h200, rv(32'h200));
    exp_resp(2'b01, 32'h104, rv(32'h104));
    exp_resp(2'b10, 32'h204, rv(32'h204));
    exp_resp(2'b01, 32'h108, rv(32'h108));
    lc_respond(32'h100, rv(32'h100));
    lc_respond(32'h200, rv(32'h200));
    lc_respond(32'h104, rv(32'h104));
    lc_respond(32'h204, rv(32'h204));
    wait_outst(1, "late_read_outstanding");
    lc_respond(32'h108, rv(32'h108));
    wait_outst(0, "fill_outstanding_zero");
    wait_drain("resp_drain");

    // port 1 read routed back with response latency of one cycle
    @(posedge clk); #1;
    bus.port_ready_in = 2'b00;
    @(negedge clk);
    grant_q.push_back(1);
    exp_req(32'h1000, 64'h0, 1'b0);
    enq(1, 32'h1000, 64'h0, 1'b0);
    wait_outst(1, "rd1000_outstanding");
    repeat (2) @(posedge clk);
    lc_respond(32'h1000, 64'hABAB_ABAB_ABAB_ABAB);
    @(negedge clk);
    chk("rd1000_valid", 64'(bus.port_valid_out), 2'b10);
    chk("rd1000_addr",  64'(bus.port_addr_out), 32'h1000);
    chk("rd1000_value", bus.port_value_out, 64'hABAB_ABAB_ABAB_ABAB);
    chk("rd1000_outstanding_zero", 64'(bus.outstanding_out), 0);
    @(posedge clk); #1;
    bus.port_ready_in = 2'b01;
    @(negedge clk);
    chk("ignore_other_ready", 64'(bus.port_valid_out), 2'b10);
    exp_resp(2'b10, 32'h1000, 64'hABAB_ABAB_ABAB_ABAB);
    @(posedge clk); #1;
    bus.port_ready_in = 2'b10;
    @(posedge clk); #1;
    bus.port_ready_in = 2'b11;
    @(negedge clk);
    chk("rd1000_cleared", 64'(bus.port_valid_out), 0);

    // downstream back-pressure holds the issued write stable
    @(posedge clk); #1;
    bus.lc_ready_in = 1'b0;
    @(negedge clk);
    grant_q.push_back(0); grant_q.push_back(1);
    exp_req(32'h2000, 64'hA5A5_0000_1234_5678, 1'b1);
    exp_req(32'h2100, 64'h5A5A_FFFF_8765_4321, 1'b1);
    enq(0, 32'h2000, 64'hA5A5_0000_1234_5678, 1'b1);
    enq(1, 32'h2100, 64'h5A5A_FFFF_8765_4321, 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.lc_valid_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_issue_seen", 64'(bus.lc_valid_out), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.lc_valid_out), 1);
      chk("stall_addr",  64'(bus.lc_addr_out), 32'h2000);
      chk("stall_value", bus.lc_value_out, 64'hA5A5_0000_1234_5678);
      chk("stall_ready", 64'(bus.port_ready_out), 0);
    end
    @(posedge clk); #1;
    bus.lc_ready_in = 1'b1;
    wait_drain("write_drain");
    chk("write_no_outstanding", 64'(bus.outstanding_out), 0);
    chk("err_clean", 64'(bus.err_out), 0);

    // stray downstream response with nothing outstanding
    @(posedge clk); #1;
    bus.lc_valid_in = 1'b1;
    bus.lc_addr_in  = 32'hDEAD;
    bus.lc_value_in = 64'h1;
    @(negedge clk);
    chk("stray_lc_ready", 64'(bus.lc_ready_out), 0);
    @(posedge clk); #1;
    bus.lc_valid_in = 1'b0;
    @(negedge clk);
    chk("stray_err", 64'(bus.err_out), 1);
    chk("stray_no_valid", 64'(bus.port_valid_out), 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(bus.err_out), 1);

    // reset with a pending response and an in-flight request
    @(posedge clk); #1;
    bus.port_ready_in = 2'b00;
    @(negedge clk);
    grant_q.push_back(1);
    exp_req(32'h3000, 64'h0, 1'b0);
    enq(1, 32'h3000, 64'h0, 1'b0);
    wait_outst(1, "rd3000_outstanding");
    lc_respond(32'h3000, rv(32'h3000));
    @(negedge clk);
    chk("pending_valid", 64'(bus.port_valid_out), 2'b10);
    @(posedge clk); #1;
    bus.lc_ready_in = 1'b0;
    @(negedge clk);
    grant_q.push_back(0);
    enq(0, 32'h3100, 64'h77, 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.lc_valid_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("inflight_seen", 64'(bus.lc_valid_out), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_port_valid",  64'(bus.port_valid_out), 0);
    chk("arst_port_ready",  64'(bus.port_ready_out), 0);
    chk("arst_lc_valid",    64'(bus.lc_valid_out), 0);
    chk("arst_lc_we",       64'(bus.lc_we_out), 0);
    chk("arst_lc_addr",     64'(bus.lc_addr_out), 0);
    chk("arst_lc_value",    bus.lc_value_out, 0);
    chk("arst_lc_ready",    64'(bus.lc_ready_out), 0);
    chk("arst_port_addr",   64'(bus.port_addr_out), 0);
    chk("arst_port_value",  bus.port_value_out, 0);
    chk("arst_outstanding", 64'(bus.outstanding_out), 0);
    chk("arst_err",         64'(bus.err_out), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.lc_ready_in   = 1'b1;
    bus.port_ready_in = 2'b11;

    // first grant after reset goes to port 0
    @(negedge clk);
    grant_q.push_back(0); grant_q.push_back(1);
    exp_req(32'h4000, 64'h40, 1'b0);
    exp_req(32'h4100, 64'h41, 1'b0);
    enq(0, 32'h4000, 64'h40, 1'b0);
    enq(1, 32'h4100, 64'h41, 1'b0);
    wait_drain("post_reset_issue");
    chk("post_reset_outstanding", 64'(bus.outstanding_out), 2);
    exp_resp(2'b01, 32'h4000, rv(32'h4000));
    exp_resp(2'b10, 32'h4100, rv(32'h4100));
    lc_respond(32'h4000, rv(32'h4000));
    lc_respond(32'h4100, rv(32'h4100));
    wait_outst(0, "final_outstanding");
    wait_drain("final_drain");
    chk("final_err", 64'(bus.err_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
